// File: rtl/mul_div_array_ctrl_pkg.sv
// Shared types and constants for the multiply/divide array sequencing controller.
// Mode encoding matches the cell-level MUL_BAR input of the array.
package mul_div_array_ctrl_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SETTLE = 2'd1,
        ST_DONE   = 2'd2
    } state_t;

    localparam logic [1:0] ERR_OK   = 2'b00;
    localparam logic [1:0] ERR_DIV0 = 2'b01;
    localparam logic [1:0] ERR_OVF  = 2'b10;

    localparam logic MODE_MUL = 1'b0;
    localparam logic MODE_DIV = 1'b1;

endpackage

// File: rtl/mul_div_array_ctrl_settle_timer.sv
// Loadable down-counter with a zero flag, used to time the array settle interval.
// The count stops at zero; a load always wins over counting.
module mul_div_array_ctrl_settle_timer #(
    parameter int W = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         load,
    input  logic [W-1:0] value,
    input  logic         en,
    output logic         zero
);

    logic [W-1:0] cnt_r;

    // Counter register: synchronous reset, load, or decrement while enabled
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_r <= '0;
        end else if (load) begin
            cnt_r <= value;
        end else if (en && (cnt_r != '0)) begin
            cnt_r <= cnt_r - W'(1);
        end else begin
            cnt_r <= cnt_r;
        end
    end

    assign zero = (cnt_r == '0);

endmodule

// File: rtl/mul_div_array_ctrl.sv
// Sequencing controller for the combinational modular multiply/divide cell array:
// registers operands onto the array, waits the settle interval, captures and holds results.
module mul_div_array_ctrl
    import mul_div_array_ctrl_pkg::*;
#(
    parameter int N      = 4,
    parameter int SETTLE = 8
) (
    input  logic           CLK,
    input  logic           RST,
    input  logic           IN_VALID,
    output logic           IN_READY,
    input  logic           MUL_BAR,
    input  logic [2*N-1:0] A,
    input  logic [N-1:0]   B,
    output logic [2*N-1:0] ARR_A,
    output logic [N-1:0]   ARR_B,
    output logic           ARR_MUL_BAR,
    input  logic [N-1:0]   ARR_HI,
    input  logic [N-1:0]   ARR_LO,
    output logic           OUT_VALID,
    input  logic           OUT_READY,
    output logic [N-1:0]   RES_HI,
    output logic [N-1:0]   RES_LO,
    output logic [1:0]     ERR
);

    localparam int CW = $clog2(SETTLE + 1);

    if ((SETTLE < 1) || (SETTLE > 255)) begin : g_bad_settle
        $error("mul_div_array_ctrl: SETTLE must be in 1..255");
    end

    state_t         state_r;
    logic           in_ready_r;
    logic           out_valid_r;
    logic [2*N-1:0] arr_a_r;
    logic [N-1:0]   arr_b_r;
    logic           arr_mul_bar_r;
    logic [N-1:0]   res_hi_r;
    logic [N-1:0]   res_lo_r;
    logic [1:0]     err_r;
    logic [1:0]     err_pend_r;

    logic           accept_s;
    logic [1:0]     err_code_s;
    logic [CW-1:0]  tmr_value_s;
    logic           tmr_en_s;
    logic           tmr_zero_s;

    // Accept decode and divide screening; a screened request waits one cycle, not SETTLE
    always_comb begin
        accept_s    = 1'b0;
        err_code_s  = ERR_OK;
        tmr_value_s = CW'(SETTLE - 1);
        if ((state_r == ST_IDLE) && IN_VALID) begin
            accept_s = 1'b1;
        end else begin
            accept_s = 1'b0;
        end
        if ((MUL_BAR == MODE_DIV) && (B == {N{1'b0}})) begin
            err_code_s = ERR_DIV0;
        end else if ((MUL_BAR == MODE_DIV) && (A[2*N-1:N] >= B)) begin
            err_code_s = ERR_OVF;
        end else begin
            err_code_s = ERR_OK;
        end
        if (err_code_s != ERR_OK) begin
            tmr_value_s = '0;
        end else begin
            tmr_value_s = CW'(SETTLE - 1);
        end
    end

    assign tmr_en_s = (state_r == ST_SETTLE);

    mul_div_array_ctrl_settle_timer #(
        .W (CW)
    ) u_settle_timer (
        .clk   (CLK),
        .rst   (RST),
        .load  (accept_s),
        .value (tmr_value_s),
        .en    (tmr_en_s),
        .zero  (tmr_zero_s)
    );

    // Controller FSM with operand and result registers
    always_ff @(posedge CLK) begin
        if (RST) begin
            state_r       <= ST_IDLE;
            in_ready_r    <= 1'b1;
            out_valid_r   <= 1'b0;
            arr_a_r       <= '0;
            arr_b_r       <= '0;
            arr_mul_bar_r <= MODE_MUL;
            res_hi_r      <= '0;
            res_lo_r      <= '0;
            err_r         <= ERR_OK;
            err_pend_r    <= ERR_OK;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (accept_s) begin
                        arr_a_r       <= A;
                        arr_b_r       <= B;
                        arr_mul_bar_r <= MUL_BAR;
                        err_pend_r    <= err_code_s;
                        in_ready_r    <= 1'b0;
                        state_r       <= ST_SETTLE;
                    end
                end
                ST_SETTLE: begin
                    if (tmr_zero_s) begin
                        if (err_pend_r != ERR_OK) begin
                            res_hi_r <= {N{1'b1}};
                            res_lo_r <= {N{1'b1}};
                        end else begin
                            res_hi_r <= ARR_HI;
                            res_lo_r <= ARR_LO;
                        end
                        err_r       <= err_pend_r;
                        out_valid_r <= 1'b1;
                        state_r     <= ST_DONE;
                    end
                end
                ST_DONE: begin
                    if (OUT_READY) begin
                        out_valid_r <= 1'b0;
                        in_ready_r  <= 1'b1;
                        state_r     <= ST_IDLE;
                    end
                end
                default: begin
                    out_valid_r <= 1'b0;
                    in_ready_r  <= 1'b1;
                    state_r     <= ST_IDLE;
                end
            endcase
        end
    end

    assign IN_READY    = in_ready_r;
    assign OUT_VALID   = out_valid_r;
    assign ARR_A       = arr_a_r;
    assign ARR_B       = arr_b_r;
    assign ARR_MUL_BAR = arr_mul_bar_r;
    assign RES_HI      = res_hi_r;
    assign RES_LO      = res_lo_r;
    assign ERR         = err_r;

endmodule

// File: tb/tb_mul_div_array_ctrl.sv
// Self-checking bench for mul_div_array_ctrl: behavioural transaction model plus
// directed vectors with hand-computed results, latencies and handshake behaviour.
module tb_mul_div_array_ctrl;

    localparam int N      = 4;
    localparam int SETTLE = 8;

    logic         CLK = 1'b0;
    logic         RST = 1'b1;
    logic         IN_VALID = 1'b0;
    logic         IN_READY;
    logic         MUL_BAR = 1'b0;
    logic [7:0]   A = 8'h00;
    logic [3:0]   B = 4'h0;
    logic [7:0]   ARR_A;
    logic [3:0]   ARR_B;
    logic         ARR_MUL_BAR;
    logic [3:0]   ARR_HI;
    logic [3:0]   ARR_LO;
    logic         OUT_VALID;
    logic         OUT_READY = 1'b0;
    logic [3:0]   RES_HI;
    logic [3:0]   RES_LO;
    logic [1:0]   ERR;

    int n_pass  = 0;
    int n_total = 0;
    int cyc     = 0;
    logic chk_en = 1'b0;

    mul_div_array_ctrl #(.N(N), .SETTLE(SETTLE)) dut (
        .CLK         (CLK),
        .RST         (RST),
        .IN_VALID    (IN_VALID),
        .IN_READY    (IN_READY),
        .MUL_BAR     (MUL_BAR),
        .A           (A),
        .B           (B),
        .ARR_A       (ARR_A),
        .ARR_B       (ARR_B),
        .ARR_MUL_BAR (ARR_MUL_BAR),
        .ARR_HI      (ARR_HI),
        .ARR_LO      (ARR_LO),
        .OUT_VALID   (OUT_VALID),
        .OUT_READY   (OUT_READY),
        .RES_HI      (RES_HI),
        .RES_LO      (RES_LO),
        .ERR         (ERR)
    );

    always #5 CLK = ~CLK;

    always @(posedge CLK) cyc <= cyc + 1;

    // Environment: behaves as the combinational array fed by the DUT's operand registers
    logic [7:0] env_prod;
    assign env_prod = 8'(ARR_A[3:0]) * 8'(ARR_B);
    assign ARR_HI = (ARR_MUL_BAR == 1'b0) ? env_prod[7:4] :
                    (ARR_B == 4'h0) ? 4'h0 : 4'(ARR_A % 8'(ARR_B));
    assign ARR_LO = (ARR_MUL_BAR == 1'b0) ? env_prod[3:0] :
                    (ARR_B == 4'h0) ? 4'h0 : 4'(ARR_A / 8'(ARR_B));

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // Transaction-level model: one request in flight, result due after a fixed latency
    logic       m_busy = 1'b0, m_valid = 1'b0;
    int         m_wait = 0;
    logic [7:0] m_arr_a = 8'h00;
    logic [3:0] m_arr_b = 4'h0;
    logic       m_arr_mb = 1'b0;
    logic [3:0] p_hi = 4'h0, p_lo = 4'h0, m_hi = 4'h0, m_lo = 4'h0;
    logic [1:0] p_err = 2'b00, m_err = 2'b00;

    always @(posedge CLK) begin
        if (RST) begin
            m_busy <= 1'b0; m_valid <= 1'b0; m_wait <= 0;
            m_arr_a <= 8'h00; m_arr_b <= 4'h0; m_arr_mb <= 1'b0;
            m_hi <= 4'h0; m_lo <= 4'h0; m_err <= 2'b00;
        end else if (!m_busy) begin
            if (IN_VALID) begin
                m_busy <= 1'b1;
                m_arr_a <= A; m_arr_b <= B; m_arr_mb <= MUL_BAR;
                if (MUL_BAR && (B == 4'h0)) begin
                    p_err <= 2'b01; p_hi <= 4'hF; p_lo <= 4'hF; m_wait <= 1;
                end else if (MUL_BAR && (A[7:4] >= B)) begin
                    p_err <= 2'b10; p_hi <= 4'hF; p_lo <= 4'hF; m_wait <= 1;
                end else if (MUL_BAR) begin
                    p_err <= 2'b00; p_hi <= 4'(A % 8'(B)); p_lo <= 4'(A / 8'(B)); m_wait <= SETTLE;
                end else begin
                    p_err <= 2'b00; {p_hi, p_lo} <= 8'(A[3:0]) * 8'(B); m_wait <= SETTLE;
                end
            end
        end else if (!m_valid) begin
            if (m_wait == 1) begin
                m_valid <= 1'b1; m_hi <= p_hi; m_lo <= p_lo; m_err <= p_err;
            end
            m_wait <= m_wait - 1;
        end else if (OUT_READY) begin
            m_valid <= 1'b0;
            m_busy  <= 1'b0;
        end
    end

    // Every-cycle comparison of all DUT outputs against the model
    always @(negedge CLK) begin
        if (chk_en) begin
            check("in_ready", 32'(IN_READY), 32'(!m_busy));
            check("out_valid", 32'(OUT_VALID), 32'(m_valid));
            check("arr_a", 32'(ARR_A), 32'(m_arr_a));
            check("arr_b", 32'(ARR_B), 32'(m_arr_b));
            check("arr_mul_bar", 32'(ARR_MUL_BAR), 32'(m_arr_mb));
            check("res_hi", 32'(RES_HI), 32'(m_hi));
            check("res_lo", 32'(RES_LO), 32'(m_lo));
            check("err", 32'(ERR), 32'(m_err));
        end
    end

    task automatic run_op(input logic mode, input logic [7:0] a, input logic [3:0] b,
                          input logic [3:0] ehi, input logic [3:0] elo, input logic [1:0] eerr,
                          input int elat, input int hold);
        int lat;
        @(posedge CLK); #1;
        check("idle_before_op", 32'(IN_READY), 32'd1);
        MUL_BAR = mode; A = a; B = b; IN_VALID = 1'b1; OUT_READY = 1'b0;
        @(posedge CLK); #1;
        IN_VALID = 1'b0;
        lat = 0;
        while (!OUT_VALID && lat < 300) begin
            check("arr_mode_settle", 32'(ARR_MUL_BAR), 32'(mode));
            @(posedge CLK); #1;
            lat++;
        end
        check("latency", 32'(lat), 32'(elat));
        check("lit_res_hi", 32'(RES_HI), 32'(ehi));
        check("lit_res_lo", 32'(RES_LO), 32'(elo));
        check("lit_err", 32'(ERR), 32'(eerr));
        for (int i = 0; i < hold; i++) begin
            IN_VALID = (i % 2 == 0); A = 8'hAA; B = 4'h3; MUL_BAR = 1'b0;
            @(posedge CLK); #1;
            check("hold_in_ready", 32'(IN_READY), 32'd0);
            check("hold_valid", 32'(OUT_VALID), 32'd1);
            check("hold_res", 32'({ERR, RES_HI, RES_LO}), 32'({eerr, ehi, elo}));
        end
        IN_VALID = 1'b0; OUT_READY = 1'b1;
        @(posedge CLK); #1;
        OUT_READY = 1'b0;
        check("xfer_valid_low", 32'(OUT_VALID), 32'd0);
        check("xfer_ready_high", 32'(IN_READY), 32'd1);
    endtask

    initial begin
        int t1, t2, n;
        logic got1;
        repeat (2) @(posedge CLK);
        #1;
        chk_en = 1'b1;
        RST = 1'b0;
        check("rst_in_ready", 32'(IN_READY), 32'd1);
        check("rst_out_valid", 32'(OUT_VALID), 32'd0);
        check("rst_res", 32'({ERR, RES_HI, RES_LO, ARR_A, ARR_B}), 32'd0);

        // 13*11 = 143 = 0x8F
        run_op(1'b0, 8'h0D, 4'hB, 4'h8, 4'hF, 2'b00, SETTLE, 0);
        // 100 / 7 = 14 rem 2, with backpressure
        run_op(1'b1, 8'h64, 4'h7, 4'h2, 4'hE, 2'b00, SETTLE, 5);
        run_op(1'b1, 8'h25, 4'h0, 4'hF, 4'hF, 2'b01, 1, 0);
        run_op(1'b1, 8'h70, 4'h7, 4'hF, 4'hF, 2'b10, 1, 2);
        // upper byte of A ignored in MUL: 0xF*0xF = 0xE1
        run_op(1'b0, 8'hAF, 4'hF, 4'hE, 4'h1, 2'b00, SETTLE, 0);

        // Reset mid-SETTLE
        @(posedge CLK); #1;
        MUL_BAR = 1'b0; A = 8'h0D; B = 4'hB; IN_VALID = 1'b1;
        @(posedge CLK); #1;
        IN_VALID = 1'b0;
        @(posedge CLK); #1;
        RST = 1'b1; OUT_READY = 1'b1;
        @(posedge CLK); #1;
        RST = 1'b0; OUT_READY = 1'b0;
        check("rst_mid_ready", 32'(IN_READY), 32'd1);
        check("rst_mid_valid", 32'(OUT_VALID), 32'd0);
        check("rst_mid_arr", 32'({ARR_MUL_BAR, ARR_A, ARR_B}), 32'd0);
        for (int i = 0; i < 15; i++) begin
            @(posedge CLK); #1;
            check("rst_no_valid", 32'(OUT_VALID), 32'd0);
        end

        // Back-to-back with OUT_READY tied high: 3*5 = 0x0F, then 7*9 = 0x3F
        OUT_READY = 1'b1;
        MUL_BAR = 1'b0; A = 8'h03; B = 4'h5; IN_VALID = 1'b1;
        @(posedge CLK); t1 = cyc; #1;
        A = 8'hF7; B = 4'h9;
        n = 0; got1 = 1'b0;
        while (!IN_READY && n < 40) begin
            if (OUT_VALID) begin
                got1 = 1'b1;
                check("b2b_res1", 32'({ERR, RES_HI, RES_LO}), 32'h00F);
            end
            @(posedge CLK); #1;
            n++;
        end
        check("b2b_first_seen", 32'(got1), 32'd1);
        @(posedge CLK); t2 = cyc; #1;
        IN_VALID = 1'b0;
        check("b2b_interval", 32'(t2 - t1), 32'(SETTLE + 2));
        n = 0;
        while (!OUT_VALID && n < 40) begin
            @(posedge CLK); #1;
            n++;
        end
        check("b2b_second_seen", 32'(OUT_VALID), 32'd1);
        check("b2b_res2", 32'({ERR, RES_HI, RES_LO}), 32'h03F);
        @(posedge CLK); #1;
        OUT_READY = 1'b0;
        repeat (3) @(posedge CLK);
        #1;

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
